// File: rtl/geo_pixel_writer.sv
// geo_pixel_writer
// Consumer end of the geometry pixel stream. Pixels arriving from the line
// generator are buffered in a small FIFO and clipped against the screen. Each
// surviving pixel becomes a linear 8bpp byte address that is written to
// display RAM through a req/ack write port.
//
// Optional feature macro: GEO_PIXEL_WRITER_TRANSPARENCY_EN
//   When defined, pixels whose colour matches transparent_color (with
//   transparent_ena high) are dropped silently after the clip test.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   pixel_data_rdy         X_coord/Y_coord/color valid this cycle
//   X_coord, Y_coord       signed 12-bit pixel coordinates
//   color                  8-bit pixel colour
//   draw_busy              back-pressure to the generator (FIFO full)
//   base_addr              address of pixel (0,0)
//   screen_width/height    unsigned screen size in pixels / rows
//   mem_wr_req/addr/data   write request toward display RAM
//   mem_ack                write accepted this cycle
//   idle                   FIFO empty and FSM in IDLE
//   clipped_count          saturating count of clipped pixels
//   transparent_ena/color  (macro only) colour-key transparency controls
module geo_pixel_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 20,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pixel_data_rdy,
    input  logic signed [11:0]  X_coord,
    input  logic signed [11:0]  Y_coord,
    input  logic [7:0]          color,
    output logic                draw_busy,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [11:0]         screen_width,
    input  logic [11:0]         screen_height,
    output logic                mem_wr_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_wr_data,
    input  logic                mem_ack,
    output logic                idle,
    output logic [CNT_W-1:0]    clipped_count
`ifdef GEO_PIXEL_WRITER_TRANSPARENCY_EN
    ,
    input  logic                transparent_ena,
    input  logic [7:0]          transparent_color
`endif
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_FW = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRITE
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_FW-1:0]  fifo_count;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    logic signed [11:0] work_x;
    logic signed [11:0] work_y;
    logic [7:0]         work_color;

    logic               clip_hit;
    logic               transparent_hit;
    logic               start_write;
    logic               count_clip;
    logic [23:0]        row_offset;
    logic [ADDR_W-1:0]  calc_addr;

    // Status decodes come only from registered state, so the generator never
    // sees a combinational path from its own inputs back through draw_busy.
    assign fifo_empty = (fifo_count == '0);
    assign draw_busy  = (fifo_count == CNT_FW'(FIFO_DEPTH));
    assign idle       = fifo_empty && (state == IDLE);
    assign push       = pixel_data_rdy && !draw_busy;

    // Negative coordinates are caught by the sign bit first, which makes the
    // unsigned comparisons against the screen size safe for the rest.
    // A zero width or height makes every pixel fail its comparison.
    assign clip_hit = work_x[11] || work_y[11] ||
                      ($unsigned(work_x) >= screen_width) ||
                      ($unsigned(work_y) >= screen_height);

`ifdef GEO_PIXEL_WRITER_TRANSPARENCY_EN
    assign transparent_hit = transparent_ena && (work_color == transparent_color);
`else
    assign transparent_hit = 1'b0;
`endif

    // Linear address: full 24-bit row product, then everything is summed at
    // the address width so the result wraps modulo 2^ADDR_W.
    assign row_offset = 24'($unsigned(work_y)) * 24'(screen_width);
    assign calc_addr  = base_addr + ADDR_W'(row_offset) + ADDR_W'($unsigned(work_x));

    // FIFO storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {X_coord, Y_coord, color};
        end
    end

    // FIFO pointers and occupancy. Pop is only ever issued when non-empty, and
    // push is refused while full, so the count can never over- or underflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_FW'(1);
                2'b01:   fifo_count <= fifo_count - CNT_FW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State register for the pop / calculate / write sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. WRITE can pop straight into CALC when more pixels are
    // waiting, which gives back-to-back writes every two cycles. mem_ack is
    // only looked at in WRITE, so stray acks elsewhere do nothing.
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        start_write = 1'b0;
        count_clip  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                if (clip_hit) begin
                    count_clip = 1'b1;
                    next_state = IDLE;
                end else if (transparent_hit) begin
                    next_state = IDLE;
                end else begin
                    start_write = 1'b1;
                    next_state  = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = CALC;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Working registers hold the pixel currently being clipped or written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work_x     <= '0;
            work_y     <= '0;
            work_color <= '0;
        end else if (pop) begin
            {work_x, work_y, work_color} <= fifo_mem[rd_ptr];
        end
    end

    // Memory write port. Address and data are loaded once in CALC and then
    // held untouched until the acknowledging edge drops the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_wr_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else if (start_write) begin
            mem_wr_req  <= 1'b1;
            mem_addr    <= calc_addr;
            mem_wr_data <= work_color;
        end else if ((state == WRITE) && mem_ack) begin
            mem_wr_req  <= 1'b0;
        end
    end

    // Clipped-pixel counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clipped_count <= '0;
        end else if (count_clip && (clipped_count != '1)) begin
            clipped_count <= clipped_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_geo_pixel_writer.sv
// tb_geo_pixel_writer
// Directed bench for geo_pixel_writer: a table of single-pixel vectors with
// hand-computed addresses and clip counts, plus hand-written sequences for
// write latency, back-pressure ordering, asynchronous reset mid-write and
// (when GEO_PIXEL_WRITER_TRANSPARENCY_EN is defined) colour-key transparency.
module tb_geo_pixel_writer;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 20;
    localparam int CNT_W      = 16;

    logic               clk;
    logic               reset_n;
    logic               pixel_data_rdy;
    logic signed [11:0] X_coord;
    logic signed [11:0] Y_coord;
    logic [7:0]         color;
    logic               draw_busy;
    logic [ADDR_W-1:0]  base_addr;
    logic [11:0]        screen_width;
    logic [11:0]        screen_height;
    logic               mem_wr_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_wr_data;
    logic               mem_ack;
    logic               idle;
    logic [CNT_W-1:0]   clipped_count;
`ifdef GEO_PIXEL_WRITER_TRANSPARENCY_EN
    logic               transparent_ena;
    logic [7:0]         transparent_color;
`endif

    geo_pixel_writer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_W(ADDR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pixel_data_rdy(pixel_data_rdy),
        .X_coord(X_coord),
        .Y_coord(Y_coord),
        .color(color),
        .draw_busy(draw_busy),
        .base_addr(base_addr),
        .screen_width(screen_width),
        .screen_height(screen_height),
        .mem_wr_req(mem_wr_req),
        .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_ack(mem_ack),
        .idle(idle),
        .clipped_count(clipped_count)
`ifdef GEO_PIXEL_WRITER_TRANSPARENCY_EN
        ,
        .transparent_ena(transparent_ena),
        .transparent_color(transparent_color)
`endif
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic [7:0]         pix_color;
        logic [19:0]        base;
        logic [11:0]        width;
        logic [11:0]        height;
        int                 exp_writes;
        logic [19:0]        exp_addr;
        int                 exp_clipped;
    } vec_t;

    vec_t vecs[12];

    int checks;
    int failures;
    int writes_seen;
    logic [19:0] got_addr;
    logic [7:0]  got_data;

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Drives one pixel for one accepting edge, then watches the write port
    // for a fixed window with mem_ack held high so any write completes at once.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        base_addr      = v.base;
        screen_width   = v.width;
        screen_height  = v.height;
        mem_ack        = 1'b1;
        X_coord        = v.x;
        Y_coord        = v.y;
        color          = v.pix_color;
        pixel_data_rdy = 1'b1;
        writes_seen    = 0;
        got_addr       = '0;
        got_data       = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pixel_data_rdy = 1'b0;
            if (mem_wr_req) begin
                writes_seen++;
                got_addr = mem_addr;
                got_data = mem_wr_data;
            end
        end
    endtask

    // Overall watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int accepted;
        int written;
        int busy_at;
        int req_wait;
        logic will_accept;
        logic [CNT_W-1:0] clip_before;

        checks         = 0;
        failures       = 0;
        reset_n        = 1'b0;
        pixel_data_rdy = 1'b0;
        X_coord        = '0;
        Y_coord        = '0;
        color          = '0;
        base_addr      = '0;
        screen_width   = 12'd640;
        screen_height  = 12'd480;
        mem_ack        = 1'b0;
`ifdef GEO_PIXEL_WRITER_TRANSPARENCY_EN
        transparent_ena   = 1'b0;
        transparent_color = 8'h00;
`endif

        vecs[0]  = '{12'sd10,    12'sd2,    8'h5A, 20'h01000, 12'd640,  12'd480,  1, 20'h0150A, 0};
        vecs[1]  = '{-12'sd1,    12'sd0,    8'h11, 20'h01000, 12'd640,  12'd480,  0, 20'h00000, 1};
        vecs[2]  = '{12'sd640,   12'sd5,    8'h22, 20'h01000, 12'd640,  12'd480,  0, 20'h00000, 2};
        vecs[3]  = '{12'sd0,     12'sd480,  8'h33, 20'h01000, 12'd640,  12'd480,  0, 20'h00000, 3};
        vecs[4]  = '{12'sd639,   12'sd479,  8'h44, 20'h01000, 12'd640,  12'd480,  1, 20'h4BFFF, 3};
        vecs[5]  = '{12'sd1,     12'sd0,    8'h55, 20'hFFFFF, 12'd640,  12'd480,  1, 20'h00000, 3};
        vecs[6]  = '{12'sd0,     12'sd0,    8'h66, 20'h00000, 12'd0,    12'd480,  0, 20'h00000, 4};
        vecs[7]  = '{12'sd5,     12'sd5,    8'h77, 20'h00000, 12'd640,  12'd0,    0, 20'h00000, 5};
        vecs[8]  = '{12'sd3,     12'sd7,    8'h88, 20'h20000, 12'd100,  12'd50,   1, 20'h202BF, 5};
        vecs[9]  = '{-12'sd2048, 12'sd10,   8'h99, 20'h00000, 12'd640,  12'd480,  0, 20'h00000, 6};
        vecs[10] = '{12'sd2047,  12'sd0,    8'hAA, 20'h00000, 12'd4095, 12'd1,    1, 20'h007FF, 6};
        vecs[11] = '{12'sd0,     12'sd2047, 8'hBB, 20'h00000, 12'd4095, 12'd2048, 1, 20'hFE801, 6};

        #12;
        checkOutput("reset_req",     32'(mem_wr_req),    32'h0);
        checkOutput("reset_addr",    32'(mem_addr),      32'h0);
        checkOutput("reset_data",    32'(mem_wr_data),   32'h0);
        checkOutput("reset_clipped", 32'(clipped_count), 32'h0);
        checkOutput("reset_busy",    32'(draw_busy),     32'h0);
        checkOutput("reset_idle",    32'(idle),          32'h1);
        @(negedge clk);
        reset_n = 1'b1;

        // Latency and hold: ack withheld, request rises on the third edge
        // counting the accepting edge, and address/data stay put until ack.
        @(negedge clk);
        base_addr      = 20'h01000;
        screen_width   = 12'd640;
        screen_height  = 12'd480;
        mem_ack        = 1'b0;
        X_coord        = 12'sd10;
        Y_coord        = 12'sd2;
        color          = 8'h5A;
        pixel_data_rdy = 1'b1;
        @(negedge clk);
        pixel_data_rdy = 1'b0;
        checkOutput("lat_after_push", 32'(mem_wr_req), 32'h0);
        checkOutput("lat_not_idle",   32'(idle),       32'h0);
        @(negedge clk);
        checkOutput("lat_after_pop",  32'(mem_wr_req), 32'h0);
        @(negedge clk);
        checkOutput("lat_after_calc", 32'(mem_wr_req), 32'h1);
        checkOutput("lat_addr",       32'(mem_addr),   32'h0150A);
        checkOutput("lat_data",       32'(mem_wr_data), 32'h5A);
        repeat (3) @(negedge clk);
        checkOutput("hold_req",  32'(mem_wr_req),  32'h1);
        checkOutput("hold_addr", 32'(mem_addr),    32'h0150A);
        checkOutput("hold_data", 32'(mem_wr_data), 32'h5A);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("ack_drops_req", 32'(mem_wr_req), 32'h0);
        checkOutput("ack_idle",      32'(idle),       32'h1);

        // Table of single-pixel vectors.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_writes", i), 32'(writes_seen), 32'(vecs[i].exp_writes));
            if (vecs[i].exp_writes > 0) begin
                checkOutput($sformatf("vec%0d_addr", i), 32'(got_addr), 32'(vecs[i].exp_addr));
                checkOutput($sformatf("vec%0d_data", i), 32'(got_data), 32'(vecs[i].pix_color));
            end
            checkOutput($sformatf("vec%0d_clipped", i), 32'(clipped_count), 32'(vecs[i].exp_clipped));
            checkOutput($sformatf("vec%0d_idle", i), 32'(idle), 32'h1);
        end

        // Back-pressure: eight pixels offered back to back with ack withheld,
        // then ack released; every pixel must be written once, in order.
        base_addr     = 20'h00000;
        screen_width  = 12'd640;
        screen_height = 12'd480;
        mem_ack       = 1'b0;
        accepted      = 0;
        written       = 0;
        busy_at       = -1;
        for (int c = 0; c < 200 && written < 8; c++) begin
            @(negedge clk);
            mem_ack = (c >= 20);
            if (c == 19) begin
                checkOutput("bp_stall_busy", 32'(draw_busy),  32'h1);
                checkOutput("bp_stall_req",  32'(mem_wr_req), 32'h1);
                checkOutput("bp_stall_addr", 32'(mem_addr),   32'h0);
            end
            if (mem_wr_req && mem_ack) begin
                checkOutput($sformatf("bp_addr%0d", written), 32'(mem_addr),    32'(written));
                checkOutput($sformatf("bp_data%0d", written), 32'(mem_wr_data), 32'(8'h80 + written));
                written++;
            end
            if (draw_busy && busy_at < 0) begin
                busy_at = accepted;
            end
            if (accepted < 8) begin
                pixel_data_rdy = 1'b1;
                X_coord        = 12'(accepted);
                Y_coord        = 12'sd0;
                color          = 8'(8'h80 + accepted);
            end else begin
                pixel_data_rdy = 1'b0;
            end
            will_accept = pixel_data_rdy && !draw_busy;
            @(posedge clk);
            if (will_accept) begin
                accepted++;
            end
        end
        pixel_data_rdy = 1'b0;
        checkOutput("bp_accepted_at_busy", 32'(busy_at),  32'd5);
        checkOutput("bp_accepted_total",   32'(accepted), 32'd8);
        checkOutput("bp_written_total",    32'(written),  32'd8);
        repeat (4) @(negedge clk);
        checkOutput("bp_idle_after", 32'(idle), 32'h1);

`ifdef GEO_PIXEL_WRITER_TRANSPARENCY_EN
        // Transparency: colour 0x00 is keyed out, 0x11 is written, and a
        // clipped pixel in the transparent colour still counts as clipped.
        clip_before       = clipped_count;
        transparent_ena   = 1'b1;
        transparent_color = 8'h00;
        mem_ack           = 1'b1;
        writes_seen       = 0;
        @(negedge clk);
        X_coord        = 12'sd0;
        Y_coord        = 12'sd0;
        color          = 8'h00;
        pixel_data_rdy = 1'b1;
        @(negedge clk);
        color = 8'h11;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pixel_data_rdy = 1'b0;
            if (mem_wr_req) begin
                writes_seen++;
                got_data = mem_wr_data;
            end
        end
        checkOutput("tr_writes",  32'(writes_seen),   32'd1);
        checkOutput("tr_data",    32'(got_data),      32'h11);
        checkOutput("tr_clipped", 32'(clipped_count), 32'(clip_before));
        @(negedge clk);
        X_coord        = -12'sd1;
        color          = 8'h00;
        pixel_data_rdy = 1'b1;
        @(negedge clk);
        pixel_data_rdy = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("tr_clip_priority", 32'(clipped_count), 32'(clip_before + 1'b1));
        transparent_ena = 1'b0;
`endif

        // Reset mid-write: request must fall asynchronously and nothing may be
        // written after reset is released.
        @(negedge clk);
        mem_ack        = 1'b0;
        base_addr      = 20'h00000;
        X_coord        = 12'sd4;
        Y_coord        = 12'sd1;
        color          = 8'h33;
        pixel_data_rdy = 1'b1;
        @(negedge clk);
        pixel_data_rdy = 1'b0;
        req_wait = 0;
        while (!mem_wr_req && req_wait < 10) begin
            @(negedge clk);
            req_wait++;
        end
        checkOutput("rst_write_reached", 32'(mem_wr_req), 32'h1);
        checkOutput("rst_pre_clipped_nonzero", 32'(clipped_count != '0), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async_req",  32'(mem_wr_req),    32'h0);
        checkOutput("rst_async_idle", 32'(idle),          32'h1);
        checkOutput("rst_async_clip", 32'(clipped_count), 32'h0);
        checkOutput("rst_async_addr", 32'(mem_addr),      32'h0);
        @(negedge clk);
        reset_n     = 1'b1;
        mem_ack     = 1'b1;
        writes_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_wr_req) begin
                writes_seen++;
            end
        end
        checkOutput("rst_no_write_after", 32'(writes_seen), 32'd0);
        checkOutput("rst_idle_after",     32'(idle),        32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
